adder: RTL and testbench

- Parameterised two's-complement binary adder; default 32 bits, also usable at 4 bits.
- Main result `sum` is purely combinational (zero-latency) from operands `a`, `b`.
- A registered copy of the result (sum, carry, overflow) is also provided for pipelined consumers on the single clock domain.
- Leaf arithmetic block used by ALU/datapath logic; no carry-in, no handshake.

---
 rtl/adder.sv | 109 ++++++++++
 tb/tb_adder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder -- parameterised two's-complement adder built from 4-bit carry-lookahead
// groups whose group generate/propagate terms are chained group to group.
//
// The combinational result (sum, cout, ovf) settles in the same cycle as a/b.
// A registered copy (sum_q, cout_q, ovf_q) follows one clock later for
// pipelined consumers.
//
// Parameters:
//   WIDTH  operand/result width; a multiple of 4 in the range 4..64
//   GROUP  lookahead group size; the group logic below is written for 4 bits
//
// Ports:
//   clk     in   1      rising-edge system clock
//   rst     in   1      synchronous active-high reset (registered outputs only)
//   a       in   WIDTH  operand A
//   b       in   WIDTH  operand B
//   sum     out  WIDTH  (a + b) mod 2^WIDTH, combinational
//   cout    out  1      carry out of the MSB, combinational
//   ovf     out  1      signed overflow, combinational
//   sum_q   out  WIDTH  sum registered
//   cout_q  out  1      cout registered
//   ovf_q   out  1      ovf registered
// -----------------------------------------------------------------------------
module adder #(
   parameter int WIDTH = 32,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic [WIDTH-1:0] sum_q,
   output logic             cout_q,
   output logic             ovf_q
);

   localparam int NG = WIDTH / GROUP;

   // Refuse to elaborate a configuration the hand-written group logic cannot
   // represent.
   if (GROUP != 4 || (WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : gen_bad_cfg
      $error("adder: WIDTH must be a multiple of 4 in 4..64 and GROUP must be 4");
   end

   // Carry into each group; gc[0] is the (absent) carry-in, gc[NG] is cout.
   logic [NG:0] gc;

   assign gc[0] = 1'b0;

   for (genvar k = 0; k < NG; k++) begin : gen_grp
      logic [3:0] g;      // bit generate
      logic [3:0] p;      // bit propagate
      logic [3:0] c;      // carry into each bit of the group
      logic       grp_g;  // group generate
      logic       grp_p;  // group propagate
      logic       cin;

      assign g   = a[k*GROUP +: GROUP] & b[k*GROUP +: GROUP];
      assign p   = a[k*GROUP +: GROUP] ^ b[k*GROUP +: GROUP];
      assign cin = gc[k];

      // Internal carries are fully flattened so each one depends only on the
      // group's g/p and its carry-in, not on the carry of the bit below.
      assign c[0] = cin;
      assign c[1] = g[0]
                  | (p[0] & cin);
      assign c[2] = g[1]
                  | (p[1] & g[0])
                  | (p[1] & p[0] & cin);
      assign c[3] = g[2]
                  | (p[2] & g[1])
                  | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & cin);

      assign grp_g = g[3]
                   | (p[3] & g[2])
                   | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]);
      assign grp_p = &p;

      // Group-to-group carry: ripple across lookahead blocks.
      assign gc[k+1] = grp_g | (grp_p & cin);

      assign sum[k*GROUP +: GROUP] = p ^ c;
   end

   assign cout = gc[NG];

   // Overflow only when both operands share a sign and the result's sign differs.
   assign ovf = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);

   // Registered copy; reset takes priority over capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         sum_q  <= sum;
         cout_q <= cout;
         ovf_q  <= ovf;
      end
   end

endmodule

// File: tb/tb_adder.sv
// -----------------------------------------------------------------------------
// tb_adder -- self-checking bench for adder (WIDTH = 32).
// Expected values come from a reference model that uses 64-bit integer
// arithmetic and a signed range test for overflow.
// -----------------------------------------------------------------------------
module tb_adder;

   localparam int W = 32;

   logic         clk;
   logic         rst;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic [W-1:0] sum_q;
   logic         cout_q;
   logic         ovf_q;

   int n_cmp = 0;
   int n_err = 0;

   // Scoreboard of expected registered results: {ovf, cout, sum}.
   logic [W+1:0] exp_q[$];

   adder #(.WIDTH(W), .GROUP(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .sum    (sum),
      .cout   (cout),
      .ovf    (ovf),
      .sum_q  (sum_q),
      .cout_q (cout_q),
      .ovf_q  (ovf_q)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      rst = 1'b1;
      a   = '0;
      b   = '0;
   end

   // ---------------- reference model ----------------
   // Returns {ovf, cout, sum} from plain integer arithmetic.
   function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
      longint ux;
      longint uy;
      longint us;
      longint sx;
      longint sy;
      longint ss;
      logic   c;
      logic   o;
      logic [W-1:0] s;
      ux = longint'(x);
      uy = longint'(y);
      us = ux + uy;
      s  = us[W-1:0];
      c  = (us >= 64'sd4294967296);
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ss = sx + sy;
      o  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      return {o, c, s};
   endfunction

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // Apply operands between rising edges and check the combinational outputs.
   task automatic drive_comb(input logic [W-1:0] ai, input logic [W-1:0] bi, input string tag);
      logic [W+1:0] e;
      @(negedge clk);
      a = ai;
      b = bi;
      #1;
      e = ref_add(ai, bi);
      check({tag, ".sum"},  64'(sum),  64'(e[W-1:0]));
      check({tag, ".cout"}, 64'(cout), 64'(e[W]));
      check({tag, ".ovf"},  64'(ovf),  64'(e[W+1]));
   endtask

   // One clock with given operands and reset; checks the registered outputs
   // just after the edge and confirms the combinational result is unaffected.
   task automatic drive_cycle(input logic [W-1:0] ai, input logic [W-1:0] bi,
                              input logic r, input string tag);
      logic [W+1:0] e;
      logic [W+1:0] m;
      @(negedge clk);
      a   = ai;
      b   = bi;
      rst = r;
      m   = ref_add(ai, bi);
      exp_q.push_back(r ? '0 : m);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({tag, ".sum_q"},  64'(sum_q),  64'(e[W-1:0]));
      check({tag, ".cout_q"}, 64'(cout_q), 64'(e[W]));
      check({tag, ".ovf_q"},  64'(ovf_q),  64'(e[W+1]));
      check({tag, ".sum"},    64'(sum),    64'(m[W-1:0]));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W+1:0] e;

      // Reset held for two edges clears the registered outputs.
      drive_cycle(32'h0000_0005, 32'h0000_0006, 1'b1, "rst0");
      drive_cycle(32'h0000_0005, 32'h0000_0006, 1'b1, "rst1");

      // Release reset, 3 + 4 appears on sum_q one edge later.
      drive_cycle(32'd3, 32'd4, 1'b0, "cap");
      check("cap.val7", 64'(sum_q), 64'd7);
      // Reset mid-stream clears sum_q while sum stays 7.
      drive_cycle(32'd3, 32'd4, 1'b1, "midrst");
      check("midrst.sum7", 64'(sum), 64'd7);
      // Capture resumes on the next edge after release.
      drive_cycle(32'd3, 32'd4, 1'b0, "resume");

      // Exhaustive low-nibble sweep: a = i % 16, b = i / 16.
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         a = W'(i % 16);
         b = W'(i / 16);
         #1;
         e = ref_add(a, b);
         check("nib.lo4", 64'(sum[3:0]), 64'((i % 16 + i / 16) % 16));
         check("nib.sum", 64'(sum), 64'(e[W-1:0]));
      end
      drive_comb(32'h0000_000F, 32'h0000_000F, "f_plus_f");
      check("f_plus_f.const", 64'(sum), 64'h1E);

      // Low nibble ignores upper operand bits.
      for (int i = 0; i < 16; i++) begin
         ra = $urandom;
         rb = $urandom;
         @(negedge clk);
         a = ra;
         b = rb;
         #1;
         check("lo4.rand", 64'(sum[3:0]), 64'((32'(ra[3:0]) + 32'(rb[3:0])) % 16));
      end

      // Directed boundary cases.
      drive_comb(32'hFFFF_FFFF, 32'h0000_0001, "wrap");
      check("wrap.const", 64'({ovf, cout, sum}), {30'd0, 1'b0, 1'b1, 32'h0000_0000});
      drive_comb(32'h7FFF_FFFF, 32'h0000_0001, "povf");
      check("povf.const", 64'({ovf, cout, sum}), {30'd0, 1'b1, 1'b0, 32'h8000_0000});
      drive_comb(32'h8000_0000, 32'h8000_0000, "novf");
      check("novf.const", 64'({ovf, cout, sum}), {30'd0, 1'b1, 1'b1, 32'h0000_0000});
      drive_comb(32'h0000_000F, 32'h0000_0001, "grp1");
      check("grp1.const", 64'(sum), 64'h0000_0010);
      drive_comb(32'h0FFF_FFFF, 32'h0000_0001, "grp7");
      check("grp7.const", 64'(sum), 64'h1000_0000);
      drive_comb(32'hFFFF_FFFF, 32'hFFFF_FFFF, "allones");
      drive_comb(32'h0000_0000, 32'h0000_0000, "zeros");

      // Random 32-bit pairs.
      for (int i = 0; i < 256; i++) begin
         ra = $urandom;
         rb = $urandom;
         drive_comb(ra, rb, "rand");
      end

      // Random registered stream with occasional reset.
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = $urandom;
         drive_cycle(ra, rb, ($urandom_range(0, 7) == 0), "rstream");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
